key_hit_queue: RTL

KEY_HIT_QUEUE -- requirements
Module: key_hit_queue

---
 rtl/key_hit_queue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/key_hit_queue.sv
// Turns keypad presses (holes 0..8) into a small FIFO of hit events.
// It also keeps a registered view of which holes are currently held.
module key_hit_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          key_valid,
   input  logic [8:0]    last_change,
   input  logic [511:0]  key_down,
   input  logic          flush,
   output logic          hit_valid,
   output logic [3:0]    hit_hole,
   input  logic          hit_ready,
   output logic [8:0]    held,
   output logic [7:0]    drop_cnt
);

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   // Handshake: the head entry transfers on any rising edge where
   // hit_valid and hit_ready are both 1; until then hit_hole holds steady.

   function automatic logic [7:0] hole_code(input int idx);
      logic [7:0] c;
      case (idx)
         0:       c = 8'h69;
         1:       c = 8'h72;
         2:       c = 8'h7A;
         3:       c = 8'h6B;
         4:       c = 8'h73;
         5:       c = 8'h74;
         6:       c = 8'h6C;
         7:       c = 8'h75;
         8:       c = 8'h7D;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   // Returns {mapped, hole}; matching all 9 bits rejects extended codes.
   function automatic logic [4:0] decode(input logic [8:0] lc);
      logic [4:0] d;
      case (lc)
         9'h069:  d = 5'h10;
         9'h072:  d = 5'h11;
         9'h07A:  d = 5'h12;
         9'h06B:  d = 5'h13;
         9'h073:  d = 5'h14;
         9'h074:  d = 5'h15;
         9'h06C:  d = 5'h16;
         9'h075:  d = 5'h17;
         9'h07D:  d = 5'h18;
         default: d = 5'h00;
      endcase
      return d;
   endfunction

   logic [3:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic [4:0]    dec;
   logic          mapped;
   logic [3:0]    ev_hole;
   logic          press;
   logic          full;
   logic          pop;
   logic          push;
   logic          drop;
   logic [8:0]    held_next;

   always_comb begin
      held_next = '0;
      for (int i = 0; i < 9; i++) begin
         held_next[i] = key_down[{1'b0, hole_code(i)}];
      end
   end

   assign dec     = decode(last_change);
   assign mapped  = dec[4];
   assign ev_hole = dec[3:0];
   assign press   = key_valid & mapped & key_down[last_change];

   assign hit_valid = (count != '0);
   // Stale storage stays hidden whenever the queue is empty.
   assign hit_hole  = hit_valid ? mem[rd_ptr] : 4'd0;

   assign full = (count == CNT_FULL);
   assign pop  = hit_valid & hit_ready;
   assign push = press & (~full | pop);
   assign drop = press & full & ~pop;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         held     <= '0;
         drop_cnt <= '0;
      end else begin
         held <= held_next;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push) begin
               wr_ptr <= wr_ptr + PTR_ONE;
            end
            case ({push, pop})
               2'b10:   count <= count + CNT_ONE;
               2'b01:   count <= count - CNT_ONE;
               default: count <= count;
            endcase
            if (drop && (drop_cnt != 8'hFF)) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

   // Storage needs no reset; count gates its visibility.
   always_ff @(posedge clk) begin
      if (rst && !flush && push) begin
         mem[wr_ptr] <= ev_hole;
      end
   end

endmodule
